// File: rtl/lrn_addr_sequencer.sv
// lrn_addr_sequencer
//   Address sequencer for the LRN engine. Walks a 4-D tensor (dim4 x dim3 x
//   dim2 x dim1) in one of two traversal orders. It issues read addresses in
//   windows of up to burst_len pixels, waits for the window buffer to fill,
//   then accepts one normalized result per pixel and issues a padded write
//   address for each result.
//
//   Handshake: a result transfers on a cycle where res_valid and res_ready are
//   both high at the rising edge of core_clk. res_ready depends only on the
//   FSM state, never on res_valid. A producer holds res_valid (and its data)
//   until the transfer. A res_valid outside PROCESS is not consumed.
//
// Ports
//   core_clk, reset            clock, asynchronous active-high reset
//   start                      begin a layer (only honoured in IDLE)
//   dim4..dim1, padding_num,
//   order_mode, burst_len      layer configuration, sampled on an accepted start
//   win_full                   window buffer loaded
//   res_valid / res_ready      result handshake
//   r_addr, r_enable           registered read address and strobe
//   w_addr, w_enable           registered write address and strobe
//   busy, done, cfg_err        status: layer in progress, layer complete pulse,
//                              start rejected pulse
//   dbg_state                  current FSM state (debug visibility)
module lrn_addr_sequencer #(
    parameter int N_WIDTH     = 2,
    parameter int M_WIDTH     = 10,
    parameter int E_WIDTH     = 6,
    parameter int F_WIDTH     = 6,
    parameter int V_WIDTH     = 2,
    parameter int ADDR_WIDTH  = 20,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   core_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N_WIDTH-1:0]     dim4,
    input  logic [M_WIDTH-1:0]     dim3,
    input  logic [E_WIDTH-1:0]     dim2,
    input  logic [F_WIDTH-1:0]     dim1,
    input  logic [V_WIDTH-1:0]     padding_num,
    input  logic                   order_mode,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   win_full,
    input  logic                   res_valid,
    output logic                   res_ready,
    output logic [ADDR_WIDTH-1:0]  r_addr,
    output logic                   r_enable,
    output logic [ADDR_WIDTH-1:0]  w_addr,
    output logic                   w_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic [2:0]             dbg_state
);

    localparam int AW = ADDR_WIDTH;
    localparam int BW = BURST_WIDTH;
    localparam int TW = N_WIDTH + M_WIDTH + E_WIDTH + F_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_READ    = 3'd2,
        S_PROCESS = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // One tensor coordinate; the same shape also holds the dimensions.
    typedef struct packed {
        logic [N_WIDTH-1:0] i4;
        logic [M_WIDTH-1:0] i3;
        logic [E_WIDTH-1:0] i2;
        logic [F_WIDTH-1:0] i1;
    } idx_t;

    state_t            state, state_nxt;

    idx_t              dim_q;
    logic [V_WIDTH-1:0] pad_q;
    logic              mode_q;
    logic [BW-1:0]     burst_q;

    logic [AW-1:0]     s3, s4, p2, w3, w4;
    logic [TW-1:0]     t_total;
    logic [TW-1:0]     wr_count;
    logic [BW-1:0]     win_len, rd_beats, wr_beats;
    logic              wf_seen;
    idx_t              rd_idx, wr_idx;

    // Advance a coordinate by one pixel in the selected order; each index
    // wraps at its dimension and carries into the next slower index.
    function automatic idx_t next_idx(input idx_t c, input idx_t d, input logic mode);
        idx_t n;
        logic l4, l3, l2, l1;
        n  = c;
        l4 = (c.i4 == d.i4 - N_WIDTH'(1));
        l3 = (c.i3 == d.i3 - M_WIDTH'(1));
        l2 = (c.i2 == d.i2 - E_WIDTH'(1));
        l1 = (c.i1 == d.i1 - F_WIDTH'(1));
        if (!mode) begin
            // i4 fastest, then i3, i2, i1
            n.i4 = l4 ? '0 : c.i4 + N_WIDTH'(1);
            if (l4) begin
                n.i3 = l3 ? '0 : c.i3 + M_WIDTH'(1);
                if (l3) begin
                    n.i2 = l2 ? '0 : c.i2 + E_WIDTH'(1);
                    if (l2) n.i1 = l1 ? '0 : c.i1 + F_WIDTH'(1);
                end
            end
        end else begin
            // i2 fastest, then i1, i3, i4
            n.i2 = l2 ? '0 : c.i2 + E_WIDTH'(1);
            if (l2) begin
                n.i1 = l1 ? '0 : c.i1 + F_WIDTH'(1);
                if (l1) begin
                    n.i3 = l3 ? '0 : c.i3 + M_WIDTH'(1);
                    if (l3) n.i4 = l4 ? '0 : c.i4 + N_WIDTH'(1);
                end
            end
        end
        return n;
    endfunction

    function automatic logic [BW-1:0] clip_win(input logic [TW-1:0] rem, input logic [BW-1:0] b);
        if (rem < TW'(b)) return rem[BW-1:0];
        return b;
    endfunction

    // ---------------- combinational helpers ----------------
    logic          cfg_ok;
    logic [TW-1:0] total_c;
    logic [AW-1:0] pad2_c, p1_c, p2_c, w3_c;
    logic [AW-1:0] rd_addr_c, wr_addr_c;
    logic          read_go, read_exit, hs, wr_last, layer_end;
    logic [TW-1:0] wr_count_inc;

    assign cfg_ok = (dim4 != '0) && (dim3 != '0) && (dim2 != '0) &&
                    (dim1 != '0) && (burst_len != '0);

    assign total_c = TW'(dim_q.i4) * TW'(dim_q.i3) * TW'(dim_q.i2) * TW'(dim_q.i1);
    assign pad2_c  = AW'(pad_q) << 1;
    assign p1_c    = AW'(dim_q.i1) + pad2_c;
    assign p2_c    = AW'(dim_q.i2) + pad2_c;
    assign w3_c    = p1_c * p2_c;

    assign rd_addr_c = AW'(rd_idx.i4) * s4 + AW'(rd_idx.i3) * s3 +
                       AW'(rd_idx.i1) * AW'(dim_q.i2) + AW'(rd_idx.i2);
    assign wr_addr_c = AW'(wr_idx.i4) * w4 + AW'(wr_idx.i3) * w3 +
                       (AW'(wr_idx.i1) + AW'(pad_q)) * p2 +
                       AW'(wr_idx.i2) + AW'(pad_q);

    assign read_go      = (state == S_READ) && (rd_beats != win_len);
    // An early win_full is remembered in wf_seen until the beats complete.
    assign read_exit    = (state == S_READ) && (rd_beats == win_len) && (win_full || wf_seen);
    assign hs           = (state == S_PROCESS) && res_valid;
    // Leave PROCESS on the handshake that completes the window so res_ready
    // never stays high for a result that would not be used.
    assign wr_last      = hs && (wr_beats == win_len - BW'(1));
    assign wr_count_inc = wr_count + TW'(1);
    assign layer_end    = (wr_count_inc == t_total);

    // ---------------- FSM ----------------
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && cfg_ok) state_nxt = S_CFG;
            S_CFG:     state_nxt = S_READ;
            S_READ:    if (read_exit) state_nxt = S_PROCESS;
            S_PROCESS: if (wr_last) state_nxt = layer_end ? S_DONE : S_READ;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign res_ready = (state == S_PROCESS);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // ---------------- datapath ----------------
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            dim_q    <= '0;
            pad_q    <= '0;
            mode_q   <= 1'b0;
            burst_q  <= '0;
            s3       <= '0;
            s4       <= '0;
            p2       <= '0;
            w3       <= '0;
            w4       <= '0;
            t_total  <= '0;
            wr_count <= '0;
            win_len  <= '0;
            rd_beats <= '0;
            wr_beats <= '0;
            wf_seen  <= 1'b0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            r_addr   <= '0;
            r_enable <= 1'b0;
            w_addr   <= '0;
            w_enable <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            w_enable <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            dim_q    <= '{i4: dim4, i3: dim3, i2: dim2, i1: dim1};
                            pad_q    <= padding_num;
                            mode_q   <= order_mode;
                            burst_q  <= burst_len;
                            wr_count <= '0;
                            rd_idx   <= '0;
                            wr_idx   <= '0;
                            wf_seen  <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_CFG: begin
                    s3       <= AW'(dim_q.i1) * AW'(dim_q.i2);
                    s4       <= AW'(dim_q.i1) * AW'(dim_q.i2) * AW'(dim_q.i3);
                    p2       <= p2_c;
                    w3       <= w3_c;
                    w4       <= w3_c * AW'(dim_q.i3);
                    t_total  <= total_c;
                    win_len  <= clip_win(total_c, burst_q);
                    rd_beats <= '0;
                    wr_beats <= '0;
                end
                S_READ: begin
                    if (read_go) begin
                        r_enable <= 1'b1;
                        r_addr   <= rd_addr_c;
                        rd_idx   <= next_idx(rd_idx, dim_q, mode_q);
                        rd_beats <= rd_beats + BW'(1);
                    end
                    if (read_exit)     wf_seen <= 1'b0;
                    else if (win_full) wf_seen <= 1'b1;
                end
                S_PROCESS: begin
                    if (hs) begin
                        w_enable <= 1'b1;
                        w_addr   <= wr_addr_c;
                        wr_idx   <= next_idx(wr_idx, dim_q, mode_q);
                        wr_beats <= wr_beats + BW'(1);
                        wr_count <= wr_count_inc;
                    end
                    if (wr_last) begin
                        rd_beats <= '0;
                        wr_beats <= '0;
                        win_len  <= clip_win(t_total - wr_count_inc, burst_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lrn_addr_sequencer.sv
module tb_lrn_addr_sequencer;
    localparam int AW = 20;

    // ---------------- clock / reset ----------------
    logic core_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 core_clk = ~core_clk;

    logic          start = 1'b0;
    logic [1:0]    dim4 = '0;
    logic [9:0]    dim3 = '0;
    logic [5:0]    dim2 = '0;
    logic [5:0]    dim1 = '0;
    logic [1:0]    padding_num = '0;
    logic          order_mode = 1'b0;
    logic [3:0]    burst_len = '0;
    logic          win_full = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [AW-1:0] r_addr, w_addr;
    logic          r_enable, w_enable, busy, done, cfg_err;
    logic [2:0]    dbg_state;

    lrn_addr_sequencer dut (
        .core_clk    (core_clk),
        .reset       (reset),
        .start       (start),
        .dim4        (dim4),
        .dim3        (dim3),
        .dim2        (dim2),
        .dim1        (dim1),
        .padding_num (padding_num),
        .order_mode  (order_mode),
        .burst_len   (burst_len),
        .win_full    (win_full),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .r_addr      (r_addr),
        .r_enable    (r_enable),
        .w_addr      (w_addr),
        .w_enable    (w_enable),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] rd_got[$];
    logic [AW-1:0] wr_got[$];
    int            win_sizes[$];
    int            first_rd_cyc;
    int            lag_errs;
    int            done_cnt;
    int            cfg_err_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input bit use_wr);
        int n;
        logic [AW-1:0] g;
        n = use_wr ? wr_got.size() : rd_got.size();
        check({tag, "_count"}, n, exp_q.size());
        foreach (exp_q[i]) begin
            if (i < n) g = use_wr ? wr_got[i] : rd_got[i];
            else       g = 'x;
            check($sformatf("%s[%0d]", tag, i), g, exp_q[i]);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one layer: pulses start, answers the first read beat of each window
    // with a win_full pulse, raises res_valid every gap-th cycle regardless of
    // res_ready, and captures every strobe. A second start is pulsed at cycle
    // busy_start_cyc while the layer is running.
    task automatic run_layer(input logic [1:0] d4, input logic [9:0] d3,
                             input logic [5:0] d2, input logic [5:0] d1,
                             input logic [1:0] p, input logic mode,
                             input logic [3:0] burst, input int gap,
                             input int busy_start_cyc);
        int cyc = 0;
        int beats = 0;
        bit wf_sent = 0;
        bit hs_prev = 0;
        bit prev_ready = 0;
        bit fin = 0;
        rd_got.delete();
        wr_got.delete();
        win_sizes.delete();
        first_rd_cyc = -1;
        lag_errs     = 0;
        done_cnt     = 0;
        cfg_err_cnt  = 0;
        @(posedge core_clk); #1;
        dim4 = d4; dim3 = d3; dim2 = d2; dim1 = d1;
        padding_num = p; order_mode = mode; burst_len = burst;
        start = 1'b1;
        while (!fin && cyc < 3000) begin
            @(posedge core_clk); #1;
            cyc++;
            start = (cyc == busy_start_cyc);
            if (w_enable !== hs_prev) lag_errs++;
            if (r_enable) begin
                rd_got.push_back(r_addr);
                beats++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (w_enable) wr_got.push_back(w_addr);
            if (cfg_err) cfg_err_cnt++;
            if (res_ready && !prev_ready) begin
                win_sizes.push_back(beats);
                beats   = 0;
                wf_sent = 0;
            end
            prev_ready = res_ready;
            win_full = 1'b0;
            if (r_enable && !wf_sent) begin
                win_full = 1'b1;
                wf_sent  = 1;
            end
            res_valid = ((cyc % gap) == 0);
            hs_prev   = res_valid && res_ready;
            if (done) begin
                done_cnt++;
                fin = 1;
            end
        end
        start = 1'b0;
        check("layer_done_reached", fin, 1);
        res_valid = 1'b0;
        win_full  = 1'b0;
        @(posedge core_clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("no_write_after_done", w_enable, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        int cnt;
        int strobes;

        // reset state
        #12;
        check("rst_r_enable", r_enable, 0);
        check("rst_w_enable", w_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_state", dbg_state, 0);
        @(negedge core_clk);
        reset = 1'b0;

        // A: 2x2x2x2, p=0, mode 0, burst 8; a start while busy must be ignored
        run_layer(2, 2, 2, 2, 0, 0, 8, 1, 10);
        exp_q = '{0, 8, 4, 12, 1, 9, 5, 13, 2, 10, 6, 14, 3, 11, 7, 15};
        check_q("a_rd", 0);
        check_q("a_wr", 1);
        check("a_first_beat_cyc", first_rd_cyc, 3);
        check("a_windows", win_sizes.size(), 2);
        check("a_win0", win_sizes[0], 8);
        check("a_win1", win_sizes[1], 8);
        check("a_lag", lag_errs, 0);
        check("a_done_cnt", done_cnt, 1);
        check("a_busy_start_no_err", cfg_err_cnt, 0);

        // B: same dims, p=1, mode 0, burst 8, results every 3rd cycle
        run_layer(2, 2, 2, 2, 1, 0, 8, 3, 0);
        exp_q = '{5, 37, 21, 53, 6, 38, 22, 54, 9, 41, 25, 57, 10, 42, 26, 58};
        check_q("b_wr", 1);
        check("b_last_wr", wr_got[wr_got.size() - 1], 58);
        check("b_lag", lag_errs, 0);

        // C: same dims, p=0, mode 1, burst 5 -> windows 5,5,5,1
        run_layer(2, 2, 2, 2, 0, 1, 5, 3, 0);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        check_q("c_rd", 0);
        check_q("c_wr", 1);
        check("c_windows", win_sizes.size(), 4);
        check("c_win0", win_sizes[0], 5);
        check("c_win1", win_sizes[1], 5);
        check("c_win2", win_sizes[2], 5);
        check("c_win3", win_sizes[3], 1);
        check("c_lag", lag_errs, 0);

        // D: dim3 = 0 rejected
        @(posedge core_clk); #1;
        dim4 = 2; dim3 = 0; dim2 = 2; dim1 = 2; burst_len = 8;
        start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        check("d_cfg_err_pulse", cfg_err, 1);
        check("d_busy", busy, 0);
        strobes = 0;
        @(posedge core_clk); #1;
        check("d_cfg_err_width", cfg_err, 0);
        for (int i = 0; i < 6; i++) begin
            if (r_enable || w_enable || busy) strobes++;
            @(posedge core_clk); #1;
        end
        check("d_no_activity", strobes, 0);

        // E: burst_len = 0 rejected
        dim3 = 2; burst_len = 0;
        start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        check("e_cfg_err_pulse", cfg_err, 1);
        check("e_busy", busy, 0);

        // F: reset in the middle of READ, then a clean restart
        dim4 = 2; dim3 = 2; dim2 = 2; dim1 = 2;
        padding_num = 0; order_mode = 0; burst_len = 8;
        start = 1'b1;
        @(posedge core_clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(posedge core_clk); #1;
            if (r_enable) cnt++;
        end
        check("f_reached_read", cnt, 2);
        check("f_pre_reset_addr", r_addr, 8);
        #2;
        reset = 1'b1;
        #1;
        check("f_rst_r_enable", r_enable, 0);
        check("f_rst_r_addr", r_addr, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_res_ready", res_ready, 0);
        check("f_rst_w_enable", w_enable, 0);
        check("f_rst_state", dbg_state, 0);
        @(negedge core_clk);
        reset = 1'b0;
        run_layer(2, 2, 2, 2, 0, 0, 8, 1, 0);
        exp_q = '{0, 8, 4, 12, 1, 9, 5, 13, 2, 10, 6, 14, 3, 11, 7, 15};
        check("f_restart_first", rd_got[0], 0);
        check_q("f_rd", 0);
        check("f_wr_count", wr_got.size(), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
